// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 serial receiver with oversampled mid-bit sampling.
// Emits each framed byte with a one-clock strobe and flags bad stop bits.
module uart_byte_rx #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 9600,
  parameter int OVS    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       drive_line,
  output logic       framing_err,
  output logic       busy
);

  localparam int DIV = CLK_HZ / (BAUD * OVS);
  localparam int TW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVS);

  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [SW-1:0] SAMP_MID  = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_t;

  state_t state, state_n;

  logic          rx_q1, rx_s;
  logic [TW-1:0] tick_cnt;
  logic [SW-1:0] samp_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          tick, mid, bit_end;
  logic          load, ferr;

  assign tick    = (state != IDLE) && (tick_cnt == TICK_LAST);
  assign mid     = tick && (samp_cnt == SAMP_MID);
  assign bit_end = tick && (samp_cnt == SAMP_LAST);

  // two-flop synchronizer for the asynchronous line
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_q1 <= rx;
      rx_s  <= rx_q1;
    end
  end

  // state register plus tick/sample/bit counters
  // (counters start at 0 on start detection, so samp_cnt==OVS/2-1
  // is the middle of every bit and its wrap is the bit boundary)
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      samp_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE) begin
        tick_cnt <= '0;
        samp_cnt <= '0;
        bit_cnt  <= '0;
      end else begin
        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        if (tick)
          samp_cnt <= samp_cnt + 1'b1;
        if (state == DATA && mid)
          bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // next-state decode
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (!rx_s) state_n = START;
      START: if (mid) state_n = rx_s ? IDLE : DATA;
      DATA:  if (bit_end && bit_cnt == 4'd8) state_n = STOP;
      STOP:  if (mid) state_n = rx_s ? IDLE : BRK;
      BRK:   if (rx_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // output decode: good stop bit loads, low stop bit flags
  always_comb begin
    load = 1'b0;
    ferr = 1'b0;
    if (state == STOP && mid) begin
      load = rx_s;
      ferr = !rx_s;
    end
  end

  // shift register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg       <= '0;
      data_out    <= '0;
      drive_line  <= 1'b0;
      framing_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      if (state == DATA && mid)
        shreg[bit_cnt[2:0]] <= rx_s;
      if (load)
        data_out <= shreg;
      drive_line  <= load;
      framing_err <= ferr;
      busy        <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: directed vectors and corner sequences
// for the 8N1 receiver at 160 clocks per bit.
module tb_uart_byte_rx;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 10_000;
  localparam int OVS    = 16;
  localparam int BIT    = 1600;
  localparam int SLOW   = 1632;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data_out;
  logic       drive_line;
  logic       framing_err;
  logic       busy;

  uart_byte_rx #(
    .CLK_HZ(CLK_HZ),
    .BAUD(BAUD),
    .OVS(OVS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .data_out(data_out),
    .drive_line(drive_line),
    .framing_err(framing_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
  } vec_t;

  int total = 0;
  int bad   = 0;

  logic [7:0] got[$];
  int         ferr_n = 0;
  int         both_n = 0;
  longint     t_pulse = 0;
  longint     t_start = 0;

  always @(negedge clk) begin
    if (drive_line) begin
      got.push_back(data_out);
      t_pulse = $time;
    end
    if (framing_err) ferr_n++;
    if (drive_line && framing_err) both_n++;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input logic stp,
                            input int bt);
    rx = 1'b0;
    t_start = $time;
    #bt;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #bt;
    end
    rx = stp;
    #bt;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t       tbl[6];
    logic [7:0] seq[4];
    logic [7:0] alt[6];
    int         p0, f0, lat;
    logic [7:0] prev;

    tbl[0].data = 8'h21;
    tbl[1].data = 8'h00;
    tbl[2].data = 8'hFF;
    tbl[3].data = 8'h80;
    tbl[4].data = 8'h01;
    tbl[5].data = 8'hC3;
    seq[0] = 8'h21;
    seq[1] = 8'h42;
    seq[2] = 8'h33;
    seq[3] = 8'h30;
    for (int i = 0; i < 6; i++)
      alt[i] = i[0] ? 8'hAA : 8'h55;

    repeat (4) @(negedge clk);
    chk("rst_data", 32'(data_out), 32'h00);
    chk("rst_drive", 32'(drive_line), 0);
    chk("rst_ferr", 32'(framing_err), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // single byte with latency
    p0 = got.size();
    f0 = ferr_n;
    send_frame(8'h21, 1'b1, BIT);
    #400;
    chk("t1_pulses", 32'(got.size() - p0), 1);
    if (got.size() > p0)
      chk("t1_data", 32'(got[p0]), 32'h21);
    chk("t1_ferr", 32'(ferr_n - f0), 0);
    lat = int'((t_pulse - t_start) / 10);
    chk("t1_lat_ok", 32'(lat >= 1500 && lat <= 1540), 1);

    // table vectors
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      p0 = got.size();
      f0 = ferr_n;
      send_frame(tbl[v].data, 1'b1, BIT);
      #400;
      chk("tbl_pulses", 32'(got.size() - p0), 1);
      if (got.size() > p0)
        chk("tbl_strobe_data", 32'(got[p0]), 32'(tbl[v].data));
      chk("tbl_data_out", 32'(data_out), 32'(tbl[v].data));
      chk("tbl_ferr", 32'(ferr_n - f0), 0);
      chk("tbl_busy", 32'(busy), 0);
    end

    // back-to-back "!B30"
    @(negedge clk);
    p0 = got.size();
    for (int i = 0; i < 4; i++)
      send_frame(seq[i], 1'b1, BIT);
    #400;
    chk("b2b_pulses", 32'(got.size() - p0), 4);
    for (int i = 0; i < 4; i++)
      if (got.size() > p0 + i)
        chk("b2b_data", 32'(got[p0 + i]), 32'(seq[i]));

    // glitch rejection
    @(negedge clk);
    p0 = got.size();
    rx = 1'b0;
    #400;
    rx = 1'b1;
    #800;
    chk("glitch_busy", 32'(busy), 0);
    chk("glitch_pulses", 32'(got.size() - p0), 0);
    @(negedge clk);
    send_frame(8'h62, 1'b1, BIT);
    #400;
    chk("glitch_next", 32'(data_out), 32'h62);
    chk("glitch_next_n", 32'(got.size() - p0), 1);

    // framing error and break
    @(negedge clk);
    p0 = got.size();
    f0 = ferr_n;
    prev = data_out;
    send_frame(8'h35, 1'b0, BIT);
    #5000;
    chk("fe_ferr", 32'(ferr_n - f0), 1);
    chk("fe_pulses", 32'(got.size() - p0), 0);
    chk("fe_data_kept", 32'(data_out), 32'(prev));
    chk("fe_busy_held", 32'(busy), 1);
    rx = 1'b1;
    #200;
    chk("fe_busy_rel", 32'(busy), 0);
    @(negedge clk);
    send_frame(8'h30, 1'b1, BIT);
    #400;
    chk("fe_next", 32'(data_out), 32'h30);
    chk("fe_next_n", 32'(got.size() - p0), 1);

    // reset in the middle of a frame
    @(negedge clk);
    p0 = got.size();
    fork
      send_frame(8'hA5, 1'b1, BIT);
      begin
        #(BIT * 4 + BIT / 2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_data", 32'(data_out), 32'h00);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_drive", 32'(drive_line), 0);
        chk("mrst_ferr", 32'(framing_err), 0);
      end
    join
    @(negedge clk);
    rst = 1'b0;
    #400;
    chk("mrst_nostrobe", 32'(got.size() - p0), 0);
    @(negedge clk);
    send_frame(8'h5A, 1'b1, BIT);
    #400;
    chk("mrst_next", 32'(data_out), 32'h5A);
    chk("mrst_next_n", 32'(got.size() - p0), 1);

    // slow sender, alternating pattern, back to back
    @(negedge clk);
    p0 = got.size();
    f0 = ferr_n;
    for (int i = 0; i < 6; i++)
      send_frame(alt[i], 1'b1, SLOW);
    #400;
    chk("slow_pulses", 32'(got.size() - p0), 6);
    chk("slow_ferr", 32'(ferr_n - f0), 0);
    for (int i = 0; i < 6; i++)
      if (got.size() > p0 + i)
        chk("slow_data", 32'(got[p0 + i]), 32'(alt[i]));

    chk("never_both", 32'(both_n), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
